// File: rtl/video_compositor.sv
// ---------------------------------------------------------------------------
// video_compositor
//   Video output stage: raster timing generator, NUM_SRC-way RGB source
//   selector that switches only on frame boundaries, and a sync/DE delay line
//   matched to the source latency so pixels and syncs leave together.
//   Optional build macro: VIDEO_FADE_EN adds a 2^FADE_SHIFT-frame crossfade
//   between the previous and the newly selected source.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module video_compositor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int NUM_SRC     = 4,
  parameter int COLOR_W     = 8,
  parameter int SRC_LATENCY = 1,
  parameter int FADE_SHIFT  = 4,
  parameter int SEL_W       = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [SEL_W-1:0]               sel,
  input  logic [NUM_SRC*3*COLOR_W-1:0]   src_rgb,
  output logic [9:0]                     video_x,
  output logic [9:0]                     video_y,
  output logic                           disp_active,
  output logic                           line_end,
  output logic                           frame_end,
  output logic [SEL_W-1:0]               sel_active,
  output logic                           fade_busy,
  output logic [COLOR_W-1:0]             r,
  output logic [COLOR_W-1:0]             g,
  output logic [COLOR_W-1:0]             b,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIX_W   = 3 * COLOR_W;

  localparam logic [9:0] C_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] C_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SEL_W:0] C_NSRC = (SEL_W + 1)'(NUM_SRC);

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  assign line_end    = (h_q == C_H_LAST);
  assign frame_end   = line_end && (v_q == C_V_LAST);
  assign video_x     = h_q;
  assign video_y     = v_q;
  assign disp_active = (h_q < C_H_ACT) && (v_q < C_V_ACT);

  // Next raster position: h wraps each line, v steps on line end and wraps per frame
  always_comb begin
    h_d = line_end ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (line_end) begin
      v_d = frame_end ? 10'd0 : v_q + 10'd1;
    end
  end

  // Raster position registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sync generation and latency-matching delay line
  // -------------------------------------------------------------------------
  logic w_hs;
  logic w_vs;
  logic [SRC_LATENCY:0] hs_q;
  logic [SRC_LATENCY:0] vs_q;
  logic [SRC_LATENCY:0] act_q;
  logic w_act_src;

  assign w_hs = ((h_q >= C_HS_START) && (h_q < C_HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign w_vs = ((v_q >= C_VS_START) && (v_q < C_VS_END)) ? SYNC_POL : ~SYNC_POL;

  // Shift syncs and active flag so they emerge alongside the registered pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q  <= {(SRC_LATENCY + 1){~SYNC_POL}};
      vs_q  <= {(SRC_LATENCY + 1){~SYNC_POL}};
      act_q <= '0;
    end else begin
      hs_q[0]  <= w_hs;
      vs_q[0]  <= w_vs;
      act_q[0] <= disp_active;
      for (int i = 1; i <= SRC_LATENCY; i++) begin
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
        act_q[i] <= act_q[i-1];
      end
    end
  end

  assign hsync = hs_q[SRC_LATENCY];
  assign vsync = vs_q[SRC_LATENCY];
  assign de    = act_q[SRC_LATENCY];

  // The active flag that lines up with src_rgb is one stage short of the output
  generate
    if (SRC_LATENCY == 0) begin : g_act_direct
      assign w_act_src = disp_active;
    end else begin : g_act_delayed
      assign w_act_src = act_q[SRC_LATENCY-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Source unpacking and frame-synchronous selection
  // -------------------------------------------------------------------------
  logic [PIX_W-1:0] w_src [NUM_SRC];
  logic [PIX_W-1:0] w_new;
  logic [PIX_W-1:0] w_pix;
  logic [SEL_W-1:0] sel_active_q, sel_active_d;
  logic             w_accept;

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      assign w_src[s] = src_rgb[s*PIX_W +: PIX_W];
    end
  endgenerate

  assign w_new      = w_src[sel_active_q];
  assign sel_active = sel_active_q;

  // A request is honoured only at frame end, if legal, different and not fading
  assign w_accept = frame_end && ({1'b0, sel} < C_NSRC) &&
                    (sel != sel_active_q) && !fade_busy;

`ifdef VIDEO_FADE_EN
  localparam int AW = FADE_SHIFT + 1;
  localparam int PW = COLOR_W + FADE_SHIFT + 1;
  localparam logic [AW-1:0] C_FADE_N = AW'(1 << FADE_SHIFT);

  logic [AW-1:0]    alpha_q, alpha_d;
  logic [SEL_W-1:0] prev_sel_q, prev_sel_d;
  logic [PIX_W-1:0] w_old;

  assign fade_busy = (alpha_q != C_FADE_N);
  assign w_old     = w_src[prev_sel_q];

  // Selection and fade progress: restart fade on accept, else advance per frame
  always_comb begin
    sel_active_d = sel_active_q;
    prev_sel_d   = prev_sel_q;
    alpha_d      = alpha_q;
    if (w_accept) begin
      prev_sel_d   = sel_active_q;
      sel_active_d = sel;
      alpha_d      = AW'(1);
    end else if (frame_end && (alpha_q != C_FADE_N)) begin
      alpha_d = alpha_q + AW'(1);
    end
  end

  // Selection and fade state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_active_q <= '0;
      prev_sel_q   <= '0;
      alpha_q      <= C_FADE_N;
    end else begin
      sel_active_q <= sel_active_d;
      prev_sel_q   <= prev_sel_d;
      alpha_q      <= alpha_d;
    end
  end

  // Per-channel weighted mix; the sum never exceeds N*max so truncation is exact floor
  generate
    for (genvar c = 0; c < 3; c++) begin : g_blend
      logic [PW-1:0] w_sum;
      assign w_sum = PW'(alpha_q) * PW'(w_new[c*COLOR_W +: COLOR_W]) +
                     PW'(C_FADE_N - alpha_q) * PW'(w_old[c*COLOR_W +: COLOR_W]);
      assign w_pix[c*COLOR_W +: COLOR_W] = COLOR_W'(w_sum >> FADE_SHIFT);
    end
  endgenerate
`else
  assign fade_busy = 1'b0;
  assign w_pix     = w_new;

  // Hard switch of the displayed source at the frame boundary
  always_comb begin
    sel_active_d = sel_active_q;
    if (w_accept) begin
      sel_active_d = sel;
    end
  end

  // Selected source register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_active_q <= '0;
    end else begin
      sel_active_q <= sel_active_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Output pixel register
  // -------------------------------------------------------------------------
  logic [PIX_W-1:0] rgb_q;

  // Load the pixel when its coordinate was visible, otherwise blank to black
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= w_act_src ? w_pix : '0;
    end
  end

  assign r = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign g = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign b = rgb_q[COLOR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_video_compositor.sv
// ---------------------------------------------------------------------------
// tb_video_compositor
//   Randomized bench for video_compositor on a small raster. The reference
//   model derives timing from the cycle count since reset, keeps per-frame
//   selection state, and delays its own pixel records by the pipeline depth.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_video_compositor;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 3;
  localparam int VA  = 8;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam bit POL = 1'b0;
  localparam int NS  = 3;
  localparam int CW  = 8;
  localparam int LAT = 3;
  localparam int FS  = 2;
  localparam int FN  = 1 << FS;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  logic              clk;
  logic              reset_n;
  logic [1:0]        sel_drv;
  logic [NS*3*CW-1:0] src_rgb;
  logic [9:0]        video_x, video_y;
  logic              disp_active, line_end, frame_end;
  logic [1:0]        sel_active;
  logic              fade_busy;
  logic [CW-1:0]     r, g, b;
  logic              hsync, vsync, de;

  video_compositor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .NUM_SRC(NS), .COLOR_W(CW),
    .SRC_LATENCY(LAT), .FADE_SHIFT(FS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel_drv), .src_rgb(src_rgb),
    .video_x(video_x), .video_y(video_y), .disp_active(disp_active),
    .line_end(line_end), .frame_end(frame_end), .sel_active(sel_active),
    .fade_busy(fade_busy), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .de(de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source model: pattern of the coordinates seen LAT clocks earlier
  logic [23:0] key [NS];
  logic [9:0]  xd [LAT];
  logic [9:0]  yd [LAT];

  function automatic logic [23:0] pat(input int s, input int x, input int y);
    logic [23:0] k;
    k = key[s];
    return {8'(x) ^ k[7:0], 8'(y) + k[15:8], 8'(x + y) ^ k[23:16]};
  endfunction

  always @(posedge clk) begin
    xd[0] <= video_x;
    yd[0] <= video_y;
    for (int i = 1; i < LAT; i++) begin
      xd[i] <= xd[i-1];
      yd[i] <= yd[i-1];
    end
  end

  always @* begin
    for (int s = 0; s < NS; s++)
      src_rgb[s*24 +: 24] = pat(s, int'(xd[LAT-1]), int'(yd[LAT-1]));
  end

  // Reference state
  int          n_tests = 0;
  int          n_fail  = 0;
  int          c       = 0;
  int          cur     = 0;
  int          prev    = 0;
  int          alpha   = FN;
  logic [26:0] hist [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, c, got, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(input int x, input int y);
    logic [23:0] nw;
    nw = pat(cur, x, y);
`ifdef VIDEO_FADE_EN
    begin
      logic [23:0] od, o;
      od = pat(prev, x, y);
      for (int ch = 0; ch < 3; ch++) begin
        int vn, vo;
        vn = int'(nw[ch*8 +: 8]);
        vo = int'(od[ch*8 +: 8]);
        o[ch*8 +: 8] = 8'((alpha * vn + (FN - alpha) * vo) / FN);
      end
      return o;
    end
`else
    return nw;
`endif
  endfunction

  task automatic check_cycle();
    int h, v;
    logic act, hs, vs, last_h, last_f, busy;
    logic [23:0] px;
    logic [26:0] expo;
    h = c % HT;
    v = (c / HT) % VT;
    act    = (h < HA) && (v < VA);
    hs     = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
    vs     = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
    last_h = (h == HT - 1);
    last_f = last_h && (v == VT - 1);
    busy   = (alpha != FN);
    px     = act ? model_pix(h, v) : 24'h0;
    hist[c % 64] = {act, hs, vs, px};
    expo = (c >= LAT + 1) ? hist[(c - LAT - 1) % 64] : {1'b0, ~POL, ~POL, 24'h0};
    chk("coord", 32'({video_y, video_x}), 32'({10'(v), 10'(h)}));
    chk("strobe", 32'({disp_active, line_end, frame_end}), 32'({act, last_h, last_f}));
    chk("de_sync", 32'({de, hsync, vsync}), 32'(expo[26:24]));
    chk("rgb", 32'({r, g, b}), 32'(expo[23:0]));
    chk("sel_active", 32'(sel_active), 32'(cur));
    chk("fade_busy", 32'(fade_busy), 32'(busy));
    if (last_f) begin
      if (int'(sel_drv) < NS && int'(sel_drv) != cur && !busy) begin
        prev = cur;
        cur  = int'(sel_drv);
`ifdef VIDEO_FADE_EN
        alpha = 1;
`endif
      end else if (alpha < FN) begin
        alpha++;
      end
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      c++;
      #2;
      if (rnd && (c % HT) == 0 && $urandom_range(0, 5) == 0)
        sel_drv = 2'($urandom_range(0, 3));
      #3 check_cycle();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_pix", 32'({r, g, b, de, hsync, vsync}), 32'({24'h0, 1'b0, ~POL, ~POL}));
    chk("rst_coord", 32'({video_y, video_x}), 32'h0);
    chk("rst_sel", 32'({sel_active, fade_busy}), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold", 32'({video_y, video_x, de}), 32'h0);
    #2 reset_n = 1'b1;
    c     = 0;
    cur   = 0;
    prev  = 0;
    alpha = FN;
    #2 check_cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    sel_drv = 2'd0;
    for (int s = 0; s < NS; s++) key[s] = 24'($urandom);
    key[0][7:0] = 8'h00;
    repeat (2) @(posedge clk);
    do_reset();
    // Source 0 for two frames, then a request mid-frame for source 2
    run(2 * FT, 1'b0);
    run(5 * HT, 1'b0);
    sel_drv = 2'd2;
    run(2 * FT, 1'b0);
    // Out-of-range request held across several frame ends
    sel_drv = 2'd3;
    run(3 * FT, 1'b0);
    sel_drv = 2'd1;
    run(FT, 1'b0);
    run(5 * FT, 1'b1);
    // Asynchronous reset in the middle of a visible line
    for (int i = 0; i < FT && !((c % HT) == 10 && ((c / HT) % VT) == 4); i++)
      run(1, 1'b1);
    do_reset();
    run(4 * FT, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_compositor.md
# video_compositor

Parametrised video output stage: integrated timing generator, an N-source RGB selector with frame-synchronous switching, latency-matched sync/DE pipeline, and an optional per-frame crossfade between sources. It sits at the top of the video path, driving pixel coordinates and line/frame strobes to all pattern sources and presenting registered RGB, HSYNC, VSYNC and DE to the TMDS/HDMI encoder.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 0, asserted level of hsync/vsync
- NUM_SRC, 4, number of RGB sources (2..16)
- COLOR_W, 8, bits per colour channel
- SRC_LATENCY, 1, clocks from video_x/video_y to valid src_rgb
- FADE_SHIFT, 4, crossfade length N = 2^FADE_SHIFT frames; used only with fade compiled in
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- sel  in  SEL_W=$clog2(NUM_SRC)  requested source, level-sensitive
- src_rgb  in  NUM_SRC*3*COLOR_W  packed {r,g,b} per source, source 0 in LSBs
- video_x, video_y  out  10 each  current pixel coordinates
- disp_active  out  1  coordinates inside the active area
- line_end  out  1  last clock of each line
- frame_end  out  1  last clock of each frame
- sel_active  out  SEL_W  source currently displayed (fade target)
- fade_busy  out  1  crossfade in progress
- r, g, b  out  COLOR_W each  registered pixel
- hsync, vsync, de  out  1 each  registered, latency-matched

## Operation
- Counters h in 0..H_TOTAL-1, v in 0..V_TOTAL-1; h wraps and v increments at line_end; v wraps at frame_end. video_x=h, video_y=v (combinational from counters).
- disp_active = h<H_ACTIVE && v<V_ACTIVE. hsync asserted (SYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v.
- hsync/vsync/disp_active pass through a delay line of SRC_LATENCY+1 stages; the final stage drives hsync/vsync/de.
- Output RGB register loads the selected (or blended) source when the delayed disp_active is 1, else 0.
- sel sampled only on frame_end. Accepted if sel<NUM_SRC, sel!=sel_active and no fade in progress; otherwise ignored (level input, re-sampled next frame_end). Accepted value takes effect from pixel (0,0) of the next frame.
- Constraint: SRC_LATENCY+1 <= H_FP+H_SYNC+H_BP; the switch therefore never splits a visible line.

## Timing
- Reset (asynchronous, immediate): h=v=0, sel_active=0, fade idle, r=g=b=0, de=0, hsync=vsync=~SYNC_POL, delay line cleared to inactive.
- First clock after release: video_x=0, video_y=0, disp_active=1.
- Pixel latency: coordinate presented at cycle t appears on r/g/b/de at cycle t+SRC_LATENCY+1; hsync/vsync share the same latency.
- H_TOTAL=800, V_TOTAL=525 with defaults.
- Reset asserted mid-line: outputs return to reset values without a clock edge; timing restarts at (0,0).

## Configuration
- VIDEO_FADE_EN defined: on accept, prev_sel<=sel_active, sel_active<=sel, alpha<=1; alpha increments at each frame_end while alpha<N; fade_busy = (alpha!=N). Output per channel = (alpha*new + (N-alpha)*old) >> FADE_SHIFT, with an intermediate width of COLOR_W+FADE_SHIFT+1 and truncation. N-1 blended frames, then pure new source. Reset alpha=N.
- VIDEO_FADE_EN undefined: no alpha or prev_sel logic; hard switch at the frame boundary; fade_busy tied 0.

## Test plan
- Reset release, defaults: de first high at cycle 2; 640 DE clocks per line; hsync low for 96 clocks starting at h=656; frame length 420000 clocks; vsync low for 2 lines starting at line 490.
- src 0 drives r=x[7:0], SRC_LATENCY=3: output r at output pixel k equals k for k=0..255 on every active line; de aligns exactly with the pattern.
- sel 0->2 changed at line 100: rest of frame remains source 0; first DE pixel of the next frame comes from source 2; sel_active=2 after frame_end.
- NUM_SRC=3, sel=3 held through several frame_end: sel_active stays at its prior value and output is unchanged.
- VIDEO_FADE_EN, FADE_SHIFT=4, old src r=0x00, new r=0xFF: frame with alpha=8 outputs r=0x7F, alpha=15 outputs r=0xEF, 16th frame outputs r=0xFF with fade_busy=0; a sel change mid-fade is ignored until done.
- reset_n pulsed low at h=300, v=200 between clock edges: r/g/b/de go to 0 and syncs go inactive immediately; after release, video_x/video_y restart at 0,0.
